dma_multich: RTL and testbench
==============================

# dma_multich

Parametrised multi-channel DMA controller, the successor to the single-channel DMA. It takes NCH independent peripheral requests and arbitrates between them round-robin. For each granted transfer it acquires the system bus with a Breq/Back handshake, reads a 1/2/4-word burst from a source address into an internal buffer, then writes that burst to a destination address. It raises a sticky per-channel interrupt on completion. It sits between the CPU/peripherals and the shared Addr_bus/Data_bus used by memory, IO_1 and IO_2.

## Interface
- AW, 32: address width.
- DW, 32: data width.
- NCH, 2: channel count, 1..8.
- clck  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- Dreq  in  NCH  per-channel level request.
- D_ack  out  NCH  one-cycle grant pulse to the selected channel.
- ch_src  in  NCH*AW  per-channel source address; channel k is bits [k*AW +: AW].
- ch_dst  in  NCH*AW  per-channel destination address.
- Data_count  in  NCH*2  per-channel burst code: 0→1 word, 1→2, 2→4, 3→illegal.
- intr  out  NCH  sticky transfer-complete flag.
- err  out  NCH  sticky illegal-code flag.
- int_clr  in  NCH  clears intr[k] and err[k].
- Breq  out  1  bus request.
- Back  in  1  bus grant.
- Addr_bus  out  AW  bus address.
- Data_bus  inout  DW  driven with the buffer word while DWrite=1, otherwise high-Z.
- DRead, DWrite  out  1  bus read/write strobes.
- Dbrust  out  2  burst code of the active transfer.

## Operation
- States: IDLE, GRANT, REQ, RD, WR, DONE.
- IDLE: channel k is eligible when Dreq[k]=1, intr[k]=0 and err[k]=0. If any channel is eligible, the arbiter picks one and the FSM goes to GRANT.
- GRANT (1 cycle): D_ack[sel]=1; latch src, dst and code for the selected channel; assert Breq.
  - Code 3: set err[sel], go to IDLE, no bus activity.
  - Otherwise go to REQ.
- REQ: hold Breq. Go to RD on the first edge with Back=1.
- RD: N = burst length.
  - Beat i drives Addr_bus=src+i with DRead=1.
  - Data_bus is captured into buf[i] on the same edge.
  - After N beats, go to WR.
- WR: beat i drives Addr_bus=dst+i, DWrite=1, Data_bus=buf[i]. After N beats, go to DONE.
- DONE (1 cycle): drop Breq; set intr[sel]; advance the round-robin pointer to sel+1 mod NCH; go to IDLE.
- Back=0 during RD or WR:
  - Deassert DRead/DWrite.
  - Hold the beat index and Addr_bus.
  - Keep Breq=1.
  - Resume at the same beat when Back returns. No beat is lost or repeated.
- Address arithmetic is word-granular and wraps modulo 2^AW.
- Dbrust equals the latched code from GRANT until DONE, and is 0 elsewhere.
- int_clr[k] and a set of intr[k] in the same cycle: set wins.
- Dreq changes after GRANT have no effect on the transfer in flight.

## Timing
- Reset=0 sampled: on that edge, state=IDLE, pointer=0, buffer cleared.
  - All outputs go to 0: D_ack, intr, err, Breq, Addr_bus, DRead, DWrite, Dbrust.
  - Data_bus is high-Z.
  - Reset mid-transfer abandons the transfer and does not set intr.
- Latency from the Dreq-sampling edge to the last WR beat, with Back already high: 1 (GRANT) + 1 (REQ) + N + N cycles.
- intr[k] is visible the cycle after DONE.
- Back-to-back transfers: IDLE always lasts at least one cycle between DONE and the next GRANT.
- Read data is expected combinationally from the slave in the cycle DRead is high, as the memory and IO blocks provide.

## Structure
- Package dma_pkg holds:
  - state enum `dma_state_t`;
  - burst code constants `BURST1`, `BURST2`, `BURST4` and `BURST_ILLEGAL`;
  - function `burst_len(code)` returning 1, 2 or 4.
- Sub-module `rr_arbiter` (NCH parameter): inputs req and pointer; outputs a one-hot grant and a valid flag. It is purely combinational.
- The 4×DW burst buffer is local to dma_multich.

## Test plan
1. Reset: drive Reset=0 for 3 cycles with Dreq=all-ones → all outputs 0 and Data_bus high-Z throughout. No D_ack until the cycle after Reset rises.
2. Single word: ch0 with src=800, dst=500, code 0; memory returns 1000 → D_ack[0] pulse, Breq, DRead at 800, then DWrite at 500 with Data_bus=1000, then intr[0]=1.
3. 4-beat burst: ch1 with src=800, dst=700, code 2; memory model returns 1000/2000/3000/4000 → reads at 800..803; writes at 700..703 with the same data in order; Dbrust=2 throughout.
4. Simultaneous requests: ch0 and ch1 both request after reset → ch0 is served first, then ch1. After int_clr and a fresh dual request → ch0 is served first again (pointer wrapped to 0).
5. Grant loss: Back=0 for 2 cycles at read beat 1 of a 4-beat transfer → strobes drop and Addr_bus holds 801. Transfer resumes; the written data is identical to scenario 3.
6. Error and abort:
   - Code 3 on ch0 → err[0]=1, no DRead/DWrite.
   - Reset=0 asserted at write beat 2 → outputs are 0 on the next edge and intr stays 0.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types, burst codes and helpers for the multi-channel DMA
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        REQ   = 3'd2,
        RD    = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } dma_state_t;

    localparam logic [1:0] BURST1        = 2'd0;
    localparam logic [1:0] BURST2        = 2'd1;
    localparam logic [1:0] BURST4        = 2'd2;
    localparam logic [1:0] BURST_ILLEGAL = 2'd3;

    function automatic logic [2:0] burst_len(input logic [1:0] code);
        case (code)
            BURST1:  return 3'd1;
            BURST2:  return 3'd2;
            BURST4:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dma_multich_if.sv
// rtl/dma_multich_if.sv - system bus handshake and strobes shared with memory and IO
interface dma_multich_if #(
    parameter int AW = 32
);
    logic          Breq;
    logic          Back;
    logic [AW-1:0] Addr_bus;
    logic          DRead;
    logic          DWrite;
    logic [1:0]    Dbrust;

    modport master (output Breq, Addr_bus, DRead, DWrite, Dbrust, input Back);
    modport slave  (input Breq, Addr_bus, DRead, DWrite, Dbrust, output Back);
endinterface

// File: rtl/dma_multich_rr_arbiter.sv
// rtl/dma_multich_rr_arbiter.sv - combinational round-robin arbiter starting at ptr
module rr_arbiter #(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]                     req,
    input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] ptr,
    output logic [NCH-1:0]                     grant,
    output logic                               valid
);

    // Walk offsets from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        grant = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            for (int k = 0; k < NCH; k++) begin
                if (req[k] && (((int'(ptr) + i) % NCH) == k)) begin
                    grant    = '0;
                    grant[k] = 1'b1;
                end
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/dma_multich.sv
// rtl/dma_multich.sv - multi-channel burst DMA with round-robin arbitration and bus handshake
module dma_multich
    import dma_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int NCH = 2
) (
    input  logic              clck,
    input  logic              Reset,
    input  logic [NCH-1:0]    Dreq,
    output logic [NCH-1:0]    D_ack,
    input  logic [NCH*AW-1:0] ch_src,
    input  logic [NCH*AW-1:0] ch_dst,
    input  logic [NCH*2-1:0]  Data_count,
    output logic [NCH-1:0]    intr,
    output logic [NCH-1:0]    err,
    input  logic [NCH-1:0]    int_clr,
    inout  wire  [DW-1:0]     Data_bus,
    dma_multich_if.master     bus
);

    localparam int PW = $clog2(NCH > 1 ? NCH : 2);

    dma_state_t     state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  sel;
    logic [AW-1:0]  src;
    logic [AW-1:0]  dst;
    logic [1:0]     code;
    logic [1:0]     beat;
    logic [DW-1:0]  burst_buf [4];

    logic [NCH-1:0] eligible;
    logic [NCH-1:0] grant;
    logic           grant_valid;
    logic [PW-1:0]  grant_idx;
    logic [AW-1:0]  grant_src;
    logic [AW-1:0]  grant_dst;
    logic [1:0]     grant_code;
    logic [NCH-1:0] sel_oh;
    logic           last_beat;

    assign eligible = Dreq & ~intr & ~err;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        grant_idx  = '0;
        grant_src  = '0;
        grant_dst  = '0;
        grant_code = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant[k]) begin
                grant_idx  = PW'(k);
                grant_src  = ch_src[k*AW +: AW];
                grant_dst  = ch_dst[k*AW +: AW];
                grant_code = Data_count[k*2 +: 2];
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < NCH; k++) begin
            sel_oh[k] = (sel == PW'(k));
        end
    end

    assign last_beat = ({1'b0, beat} == (burst_len(code) - 3'd1));
    assign D_ack     = (state == GRANT) ? sel_oh : '0;

    always_comb begin
        bus.Breq     = ((state == GRANT) && (code != BURST_ILLEGAL)) ||
                       (state == REQ) || (state == RD) || (state == WR);
        bus.DRead    = (state == RD) && bus.Back;
        bus.DWrite   = (state == WR) && bus.Back;
        bus.Dbrust   = (state == IDLE) ? 2'b00 : code;
        case (state)
            RD:      bus.Addr_bus = src + AW'(beat);
            WR:      bus.Addr_bus = dst + AW'(beat);
            default: bus.Addr_bus = '0;
        endcase
    end

    assign Data_bus = bus.DWrite ? burst_buf[beat] : {DW{1'bz}};

    // A later write to intr/err in the same cycle overrides the clear, so a set wins.
    always_ff @(posedge clck) begin
        if (!Reset) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            src   <= '0;
            dst   <= '0;
            code  <= '0;
            beat  <= '0;
            intr  <= '0;
            err   <= '0;
            for (int i = 0; i < 4; i++) burst_buf[i] <= '0;
        end else begin
            intr <= intr & ~int_clr;
            err  <= err & ~int_clr;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        sel   <= grant_idx;
                        src   <= grant_src;
                        dst   <= grant_dst;
                        code  <= grant_code;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    beat <= '0;
                    if (code == BURST_ILLEGAL) begin
                        err   <= (err & ~int_clr) | sel_oh;
                        state <= IDLE;
                    end else begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.Back) state <= RD;
                end
                RD: begin
                    if (bus.Back) begin
                        burst_buf[beat] <= Data_bus;
                        if (last_beat) begin
                            beat  <= '0;
                            state <= WR;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                WR: begin
                    if (bus.Back) begin
                        if (last_beat) begin
                            beat  <= '0;
                            state <= DONE;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                DONE: begin
                    intr  <= (intr & ~int_clr) | sel_oh;
                    ptr   <= (sel == PW'(NCH - 1)) ? '0 : sel + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_multich.sv
// tb/tb_dma_multich.sv - randomized self-checking bench for dma_multich against a transfer-level model
module tb_dma_multich;
    import dma_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NCH = 2;

    logic              clck = 1'b0;
    logic              Reset;
    logic [NCH-1:0]    Dreq;
    logic [NCH-1:0]    D_ack;
    logic [NCH*AW-1:0] ch_src;
    logic [NCH*AW-1:0] ch_dst;
    logic [NCH*2-1:0]  Data_count;
    logic [NCH-1:0]    intr;
    logic [NCH-1:0]    err;
    logic [NCH-1:0]    int_clr;
    tri   [DW-1:0]     data_bus;
    logic              back_q;

    dma_multich_if #(.AW(AW)) bus ();
    assign bus.Back = back_q;

    dma_multich #(.AW(AW), .DW(DW), .NCH(NCH)) dut (
        .clck       (clck),
        .Reset      (Reset),
        .Dreq       (Dreq),
        .D_ack      (D_ack),
        .ch_src     (ch_src),
        .ch_dst     (ch_dst),
        .Data_count (Data_count),
        .intr       (intr),
        .err        (err),
        .int_clr    (int_clr),
        .Data_bus   (data_bus),
        .bus        (bus)
    );

    always #5 clck = ~clck;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memory: 800..803 hold 1000..4000, everything else a pattern of the address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - 32'd800;
        if (off < 32'd4) return (off + 32'd1) * 32'd1000;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign data_bus = bus.DRead ? mem_word(bus.Addr_bus) : {DW{1'bz}};

    int             m_ptr;
    logic [NCH-1:0] m_intr;
    logic [NCH-1:0] m_err;
    logic [1:0]     exp_code;
    logic [AW-1:0]  rd_q[$];
    logic [AW-1:0]  wa_q[$];
    logic [DW-1:0]  wd_q[$];
    int             dbrust_bad;
    logic           rand_back;
    logic           stall_arm;
    logic [AW-1:0]  stall_at;

    always @(posedge clck) cyc++;

    always @(negedge clck) begin
        if (bus.DRead) rd_q.push_back(bus.Addr_bus);
        if (bus.DWrite) begin
            wa_q.push_back(bus.Addr_bus);
            wd_q.push_back(data_bus);
        end
        if ((bus.DRead || bus.DWrite) && (bus.Dbrust != exp_code)) dbrust_bad++;
    end

    always @(posedge clck) begin
        #1;
        if (stall_arm && bus.DRead && (bus.Addr_bus == stall_at)) begin
            stall_arm = 1'b0;
            back_q    = 1'b0;
            repeat (2) begin
                @(negedge clck);
                check("stall_strobe", {bus.DRead, bus.DWrite}, 0);
                check("stall_addr", bus.Addr_bus, stall_at);
                check("stall_breq", bus.Breq, 1);
                @(posedge clck);
                #1;
            end
            back_q = 1'b1;
        end else begin
            back_q = rand_back ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    function automatic int pick();
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (m_ptr + i) % NCH;
            if (Dreq[c] && !m_intr[c] && !m_err[c]) return c;
        end
        return -1;
    endfunction

    task automatic serve_one(input bit chk_lat);
        int            ch, n, t, t0;
        logic [AW-1:0] src, dst, ea;
        logic [1:0]    code;
        ch = pick();
        if (ch < 0) return;
        src  = ch_src[ch*AW +: AW];
        dst  = ch_dst[ch*AW +: AW];
        code = Data_count[ch*2 +: 2];
        exp_code = code;
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        dbrust_bad = 0;
        t = 0;
        do begin
            @(negedge clck);
            t++;
        end while (D_ack == '0 && t < 60);
        check("d_ack", D_ack, 64'd1 << ch);
        t0 = cyc;
        if (code == 2'd3) begin
            m_err[ch] = 1'b1;
            @(negedge clck);
            check("err_vec", err, m_err);
            check("err_no_bus", rd_q.size() + wa_q.size(), 0);
            return;
        end
        n = (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : 4;
        t = 0;
        do begin
            @(negedge clck);
            t++;
        end while (!intr[ch] && t < 400);
        check("intr_set", intr[ch], 1);
        if (chk_lat) check("latency", cyc - t0, 2 * n + 3);
        check("rd_beats", rd_q.size(), n);
        check("wr_beats", wa_q.size(), n);
        for (int i = 0; i < n && i < rd_q.size(); i++) begin
            ea = src + AW'(i);
            check("rd_addr", rd_q[i], ea);
        end
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            ea = dst + AW'(i);
            check("wr_addr", wa_q[i], ea);
            ea = src + AW'(i);
            check("wr_data", wd_q[i], mem_word(ea));
        end
        check("dbrust", dbrust_bad, 0);
        m_intr[ch] = 1'b1;
        m_ptr      = (ch + 1) % NCH;
        check("intr_vec", intr, m_intr);
    endtask

    task automatic clear_all();
        @(posedge clck);
        #1;
        Dreq    = '0;
        int_clr = '1;
        @(posedge clck);
        #1;
        int_clr = '0;
        m_intr  = '0;
        m_err   = '0;
    endtask

    initial begin
        int t;
        Reset      = 1'b0;
        Dreq       = '1;
        int_clr    = '0;
        back_q     = 1'b1;
        rand_back  = 1'b0;
        stall_arm  = 1'b0;
        stall_at   = 32'd801;
        ch_src     = {32'd800, 32'd800};
        ch_dst     = {32'd700, 32'd500};
        Data_count = {2'd2, 2'd0};
        m_ptr      = 0;
        m_intr     = '0;
        m_err      = '0;
        exp_code   = '0;
        dbrust_bad = 0;

        repeat (3) begin
            @(posedge clck);
            @(negedge clck);
            check("rst_out", {D_ack, intr, err, bus.Breq, bus.DRead, bus.DWrite, bus.Dbrust}, 0);
            check("rst_addr", bus.Addr_bus, 0);
            check("rst_hiz", data_bus === {DW{1'bz}}, 1);
        end
        @(posedge clck);
        #1 Reset = 1'b1;
        @(negedge clck);
        check("no_early_ack", D_ack, 0);

        serve_one(1);
        serve_one(1);
        clear_all();
        Dreq = '1;
        serve_one(1);
        serve_one(1);

        clear_all();
        stall_arm = 1'b1;
        Dreq      = 2'b10;
        serve_one(0);
        check("stall_hit", stall_arm, 0);

        clear_all();
        Data_count[1:0] = 2'd3;
        Dreq            = 2'b01;
        serve_one(0);

        clear_all();
        Data_count[1:0] = 2'd2;
        ch_dst[31:0]    = 32'd900;
        Dreq            = 2'b01;
        t = 0;
        do begin
            @(negedge clck);
            t++;
        end while (!(bus.DWrite && bus.Addr_bus == 32'd902) && t < 60);
        check("abort_wb2", bus.DWrite && (bus.Addr_bus == 32'd902), 1);
        Reset = 1'b0;
        @(negedge clck);
        check("abort_out", {D_ack, intr, err, bus.Breq, bus.DRead, bus.DWrite, bus.Dbrust}, 0);
        check("abort_addr", bus.Addr_bus, 0);
        check("abort_hiz", data_bus === {DW{1'bz}}, 1);
        @(posedge clck);
        #1;
        Dreq   = '0;
        Reset  = 1'b1;
        m_ptr  = 0;
        m_intr = '0;
        m_err  = '0;

        rand_back = 1'b1;
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < NCH; k++) begin
                ch_src[k*AW +: AW]    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
                ch_dst[k*AW +: AW]    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
                Data_count[k*2 +: 2]  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            Dreq = NCH'($urandom_range(1, (1 << NCH) - 1));
            while (pick() >= 0) serve_one(0);
            clear_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
